seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
//  - Holds a NUM_DIG-nibble display value and steps through the digits one at a time.
//  - Drives one shared SEG7_LUT decoder plus active-low digit enables.
//  - New values are accepted at any time but only become visible at a frame boundary,
//    so a frame never shows a mix of old and new digits.
//  - Sits between the FFT result/status logic (producer) and the board display pins.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/SEG7_LUT.sv | 28 ++
 rtl/seg7_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scan controller.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [6:0] SEG_BLANK7 = 7'h7F;

  typedef enum logic {
    ST_DEAD,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/SEG7_LUT.sv
// Hex nibble to active-low 7-segment pattern (bit order g..a), common-anode display.
module SEG7_LUT (
  input  logic [3:0] iDIG,
  output logic [6:0] oSEG
);

  always_comb begin
    unique case (iDIG)
      4'h0: oSEG = 7'h40;
      4'h1: oSEG = 7'h79;
      4'h2: oSEG = 7'h24;
      4'h3: oSEG = 7'h30;
      4'h4: oSEG = 7'h19;
      4'h5: oSEG = 7'h12;
      4'h6: oSEG = 7'h02;
      4'h7: oSEG = 7'h78;
      4'h8: oSEG = 7'h00;
      4'h9: oSEG = 7'h10;
      4'hA: oSEG = 7'h08;
      4'hB: oSEG = 7'h03;
      4'hC: oSEG = 7'h46;
      4'hD: oSEG = 7'h21;
      4'hE: oSEG = 7'h06;
      4'hF: oSEG = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// New values wait in a shadow register and are moved to the display only at frame end.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIG  = 8,
  parameter int PRESCALE = 50000,
  parameter int IDX_W    = $clog2(NUM_DIG)
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [4*NUM_DIG-1:0]   iVALUE,
  input  logic [NUM_DIG-1:0]     iDP,
  input  logic                   iLZB,
  input  logic                   iLOAD,
  output logic                   oACK,
  output logic                   oFRAME,
  output logic [7:0]             oSEG,
  output logic [NUM_DIG-1:0]     oAN
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int VAL_W = 4 * NUM_DIG;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   shadow_q, shadow_d;
  logic [NUM_DIG-1:0] dp_shadow_q, dp_shadow_d;
  logic [VAL_W-1:0]   disp_q, disp_d;
  logic [NUM_DIG-1:0] dp_disp_q, dp_disp_d;
  logic               pending_q, pending_d;
  logic [7:0]         seg_q, seg_d;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic               ack_q, ack_d;
  logic               frame_q, frame_d;

  logic               tick;
  logic               last_dig;
  logic               xfer;
  logic [NUM_DIG-1:0] nz_suffix;
  logic               blank_cur;
  logic [3:0]         nibble_cur;
  logic [6:0]         lut_seg;

  assign tick       = (cnt_q == CNT_W'(PRESCALE - 1));
  assign last_dig   = (idx_q == IDX_W'(NUM_DIG - 1));
  assign xfer       = (state_q == ST_SHOW) && tick && last_dig;
  assign nibble_cur = disp_q[4*int'(idx_q) +: 4];

  // nz_suffix[k] is set when any nibble from k up to the most significant is non-zero.
  always_comb begin
    nz_suffix = '0;
    nz_suffix[NUM_DIG-1] = |disp_q[VAL_W-1 -: 4];
    for (int k = NUM_DIG - 2; k >= 0; k--) begin
      nz_suffix[k] = nz_suffix[k+1] | (|disp_q[4*k +: 4]);
    end
  end

  assign blank_cur = iLZB && (idx_q != '0) && !nz_suffix[idx_q];

  SEG7_LUT u_lut (
    .iDIG (nibble_cur),
    .oSEG (lut_seg)
  );

  // NOTE: every register gets a default in this block, so no latch is inferred.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    disp_d      = disp_q;
    dp_disp_d   = dp_disp_q;
    pending_d   = pending_q;
    ack_d       = iLOAD;
    frame_d     = xfer;

    unique case (state_q)
      ST_DEAD: state_d = ST_SHOW;
      ST_SHOW: begin
        if (tick) begin
          state_d = ST_DEAD;
          idx_d   = last_dig ? '0 : idx_q + IDX_W'(1);
        end
      end
    endcase

    // The transfer reads the old shadow, so a load in the same cycle waits a frame.
    if (xfer) begin
      pending_d = 1'b0;
      if (pending_q) begin
        disp_d    = shadow_q;
        dp_disp_d = dp_shadow_q;
      end
    end
    if (iLOAD) begin
      shadow_d    = iVALUE;
      dp_shadow_d = iDP;
      pending_d   = 1'b1;
    end

    // Outputs are decoded from the next state so the anode and segment flops switch together.
    if (state_d == ST_SHOW) begin
      an_d  = ~(NUM_DIG'(1) << idx_q);
      seg_d = {~dp_disp_q[idx_q], blank_cur ? SEG_BLANK7 : lut_seg};
    end else begin
      an_d  = '1;
      seg_d = SEG_OFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q       <= '0;
      state_q     <= ST_DEAD;
      idx_q       <= '0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      disp_q      <= '0;
      dp_disp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      disp_q      <= disp_d;
      dp_disp_q   <= dp_disp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      ack_q       <= ack_d;
      frame_q     <= frame_d;
    end
  end

  assign oSEG   = seg_q;
  assign oAN    = an_q;
  assign oACK   = ack_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues expected slot patterns per frame,
// a monitor pops one entry at the start of each lit digit slot.
module tb_seg7_scan_ctrl;

  localparam int NUM_DIG  = 4;
  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lzb;
  logic        load;
  logic        ack;
  logic        frame;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIG  (NUM_DIG),
    .PRESCALE (PRESCALE),
    .IDX_W    (2)
  ) dut (
    .iCLK   (clk),
    .iRST   (rst),
    .iVALUE (value),
    .iDP    (dp),
    .iLZB   (lzb),
    .iLOAD  (load),
    .oACK   (ack),
    .oFRAME (frame),
    .oSEG   (seg),
    .oAN    (an)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        ack_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acknowledge model: one cycle after any accepted load.
  always @(posedge clk) ack_exp <= load && !rst;

  initial begin : monitor
    logic [3:0]  prev_an;
    int          dead_cnt;
    bit          in_rst;
    logic [11:0] e;
    prev_an  = 4'hF;
    dead_cnt = 0;
    in_rst   = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) in_rst = 1'b1;
      if (mon_en) begin
        check("onehot0_an", 32'($onehot0(~an)), 32'd1);
        check("ack", 32'(ack), 32'(ack_exp));
        if (an == 4'hF) begin
          dead_cnt++;
        end else if (prev_an == 4'hF) begin
          if (!in_rst) check("dead_len", 32'(dead_cnt), 32'd1);
          in_rst   = 1'b0;
          dead_cnt = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("slot_an", 32'(an), 32'(e[11:8]));
            check("slot_seg", 32'(seg), 32'(e[7:0]));
          end
        end
      end
      prev_an = an;
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (frame) begin
        got = 1'b1;
        break;
      end
    end
    check("frame_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_empty();
    bit done = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("queue_drained", 32'(done), 32'd1);
    if (!done) exp_q.delete();
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back({4'b1110, s0});
    exp_q.push_back({4'b1101, s1});
    exp_q.push_back({4'b1011, s2});
    exp_q.push_back({4'b0111, s3});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit found;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    dp    = '0;
    lzb   = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'h0F);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    rst = 1'b0;

    // Plain hex value, no blanking.
    do_load(16'h1234, 4'b0000);
    wait_frame();
    push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
    wait_empty();

    // Leading-zero blanking.
    lzb = 1'b1;
    do_load(16'h0000, 4'b0000);
    wait_frame();
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    wait_empty();
    do_load(16'h0500, 4'b0000);
    wait_frame();
    push_frame(8'hC0, 8'hC0, 8'h92, 8'hFF);
    wait_empty();

    // Blanked digit keeps its decimal point.
    do_load(16'h0000, 4'b0100);
    wait_frame();
    push_frame(8'hC0, 8'hFF, 8'h7F, 8'hFF);
    wait_empty();

    // Two loads inside one frame: old value until the boundary, then only the latest.
    lzb = 1'b0;
    wait_frame();
    push_frame(8'hC0, 8'hC0, 8'h40, 8'hC0);
    do_load(16'hAAAA, 4'b0000);
    do_load(16'hBBBB, 4'b0000);
    wait_empty();
    wait_frame();
    push_frame(8'h83, 8'h83, 8'h83, 8'h83);

    // Load coinciding with the transfer tick (last show cycle of digit 3).
    do_load(16'h1111, 4'b0000);
    wait_empty();
    @(negedge clk);
    @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_frame();
    push_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9);
    wait_empty();
    wait_frame();
    push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);
    wait_empty();

    // Reset while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check("digit2_seen", 32'(found), 32'd1);
    rst = 1'b1;
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(posedge clk);
    #1;
    check("midrst_an", 32'(an), 32'h0F);
    check("midrst_seg", 32'(seg), 32'hFF);
    check("midrst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
